uart_avalon_arbiter: RTL and testbench
======================================

// Module: uart_avalon_arbiter
// PURPOSE
// Shares the single Avalon-MM port of the UART core between a read client (RX byte fetch
// for the instruction assembler) and a write client (TX byte output). After reset it
// writes the UART control register once (interrupt enable), then arbitrates one-byte
// transactions round-robin and sequences chipselect/read_n/write_n against waitrequest_in.
// Each access has a bounded wait. Sits between the UART core and the instruction/TX logic.
// PARAMETERS
// CTRL_INIT      32'h0000_0001  value written to control register (address 1) after reset
// TIMEOUT_CYCLES 255            max cycles waitrequest_in may stall one access (1..65535)
// PORTS
// clock_in        in   1   system clock, all logic on rising edge
// reset_in        in   1   synchronous, active-high reset
// rd_req_in       in   1   level; read client wants one RX byte, held until rd_done_out
// rd_done_out     out  1   1-cycle pulse; rd_* outputs valid this cycle
// rd_data_out     out  8   readdata_in[7:0] of completed read
// rd_valid_out    out  1   readdata_in[15] (RVALID): byte was present
// rd_avail_out    out  16  readdata_in[31:16] (RAVAIL): bytes remaining in RX FIFO
// wr_req_in       in   1   level; write client wants to send wr_data_in, held until wr_done_out
// wr_data_in      in   8   TX byte, sampled on grant
// wr_done_out     out  1   1-cycle pulse; write accepted (or timed out)
// error_out       out  1   1-cycle pulse coincident with a done pulse when access timed out
// init_done_out   out  1   high once control-register write completed; stays high
// chipselect_out  out  1   Avalon chipselect
// address_out     out  1   0 = data register, 1 = control register
// read_n_out      out  1   Avalon read, active low
// write_n_out     out  1   Avalon write, active low
// writedata_out   out  32  Avalon write data
// readdata_in     in   32  Avalon read data
// waitrequest_in  in   1   Avalon waitrequest, active high
// BEHAVIOUR
// - Reset (reset_in=1 at an edge, any state, incl. mid-access): next cycle chipselect_out=0,
//   read_n_out=1, write_n_out=1, address_out=0, writedata_out=0, all done/error pulses 0,
//   rd_data_out=0, rd_valid_out=0, rd_avail_out=0, init_done_out=0, last_grant=WRITE,
//   timeout counter=0, state=INIT. Aborted access produces no done pulse.
// - All Avalon outputs registered. Bus idle values as after reset.
// - States: INIT -> INIT_WAIT -> IDLE -> {RD_ACC | WR_ACC} -> DONE -> IDLE.
//   INIT: first cycle after reset released: drive cs=1, address=1, write_n=0,
//   writedata=CTRL_INIT; go INIT_WAIT.
//   *_WAIT/*_ACC: hold all bus signals stable while waitrequest_in=1; transfer completes on
//   the first edge where waitrequest_in=0; bus returns idle on that edge.
//   INIT completion sets init_done_out; rd/wr requests ignored until then.
//   IDLE: sample requests; only rd -> RD_ACC; only wr -> WR_ACC; both -> client != last_grant
//   (first contention after reset goes to read). last_grant updates on grant.
//   RD_ACC: cs=1, address=0, read_n=0. Completion latches readdata_in fields into rd_*.
//   WR_ACC: cs=1, address=0, write_n=0, writedata={24'h0, wr_data_in latched at grant}.
//   DONE: one cycle; pulse rd_done_out or wr_done_out; return to IDLE. A client still
//   requesting in DONE is not re-granted until IDLE samples it (min 1 idle bus cycle).
// - Latency: request seen at IDLE edge N -> bus active from N+1 -> with waitrequest_in=0
//   completes at edge N+2 -> done pulse cycle N+2..N+3. Each stall cycle adds one.
// - Timeout: counter counts cycles of waitrequest_in=1 within one access; reaching
//   TIMEOUT_CYCLES ends access (bus idle), done pulse with error_out=1, rd_* not updated.
//   INIT timeout: init_done_out still set, no error pulse (no client).
// - Counter clears at each access start; rd_* hold value between reads.
// - Requests dropped before grant are simply not served; dropped after grant: access
//   completes, done pulse still issued.
// TESTING
// 1 Reset release, waitrequest_in=0 -> 1 cycle cs=1,address=1,write_n=0,writedata=32'h1; init_done_out=1 next.
// 2 rd_req_in=1, readdata_in=32'h0003_8041, 2 stall cycles -> read_n_out low 3 cycles; rd_done_out pulse, rd_data_out=8'h41, rd_valid_out=1, rd_avail_out=16'h0003.
// 3 rd_req_in and wr_req_in (wr_data_in=8'h5A) both held -> grants alternate R,W,R,W; writedata_out=32'h0000_005A on writes.
// 4 wr_req_in=1, waitrequest_in stuck 1, TIMEOUT_CYCLES=4 -> bus idle after 4 stall cycles; wr_done_out and error_out pulse together.
// 5 reset_in=1 during RD_ACC stall -> next cycle bus idle, no rd_done_out, INIT write repeats.
// 6 rd_req_in held continuously, waitrequest_in=0 -> one read every 3 cycles, chipselect_out low 1+ cycle between.

Source files
------------

// File: rtl/uart_avalon_arbiter_if.sv
// Avalon-MM bus bundle between the arbiter and the UART core.
// master: arbiter side (drives chipselect/address/read_n/write_n/writedata,
//         receives readdata/waitrequest).
// slave:  UART core side.
interface uart_avalon_arbiter_if;
  logic        chipselect_out;
  logic        address_out;
  logic        read_n_out;
  logic        write_n_out;
  logic [31:0] writedata_out;
  logic [31:0] readdata_in;
  logic        waitrequest_in;

  modport master (
    output chipselect_out, address_out, read_n_out, write_n_out, writedata_out,
    input  readdata_in, waitrequest_in
  );

  modport slave (
    input  chipselect_out, address_out, read_n_out, write_n_out, writedata_out,
    output readdata_in, waitrequest_in
  );
endinterface

// File: rtl/uart_avalon_arbiter.sv
// Shares the UART core's single Avalon-MM port between a read client (RX byte
// fetch) and a write client (TX byte output). After reset the control register
// is written once with CTRL_INIT, then one-byte accesses are granted
// round-robin. Every access is bounded by TIMEOUT_CYCLES of waitrequest stall.
// Ports:
//   clock_in, reset_in          clock, synchronous active-high reset
//   rd_req_in / rd_done_out     read client handshake; rd_data/valid/avail results
//   wr_req_in / wr_data_in      write client request and byte
//   wr_done_out, error_out      write completion, timeout flag on any done pulse
//   init_done_out               control-register write finished (sticky)
//   bus                         Avalon-MM master modport (all outputs registered)
module uart_avalon_arbiter #(
  parameter logic [31:0] CTRL_INIT      = 32'h0000_0001,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        rd_req_in,
  output logic        rd_done_out,
  output logic [7:0]  rd_data_out,
  output logic        rd_valid_out,
  output logic [15:0] rd_avail_out,
  input  logic        wr_req_in,
  input  logic [7:0]  wr_data_in,
  output logic        wr_done_out,
  output logic        error_out,
  output logic        init_done_out,
  uart_avalon_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_INIT, S_INIT_WAIT, S_IDLE, S_RD_ACC, S_WR_ACC, S_DONE
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        cs, cs_nxt, addr, addr_nxt, rdn, rdn_nxt, wrn, wrn_nxt;
  logic [31:0] wd, wd_nxt;
  logic [7:0]  rdata, rdata_nxt;
  logic        rvalid, rvalid_nxt;
  logic [15:0] ravail, ravail_nxt;
  logic        rdone, rdone_nxt, wdone, wdone_nxt, err, err_nxt;
  logic        init_done, init_done_nxt;
  logic        last_wr, last_wr_nxt;   // 1: last grant went to the write client
  logic [15:0] tcnt, tcnt_nxt;
  logic        bus_idle, timed_out, grant_rd;

  // Bits 14:8 of the data register carry nothing the clients need.
  logic unused_rdata;
  assign unused_rdata = ^bus.readdata_in[14:8];

  // Stall that would be the TIMEOUT_CYCLES-th one ends the access.
  assign timed_out = bus.waitrequest_in && (tcnt == TO_LAST);
  // Read wins when alone, or under contention when write was served last.
  assign grant_rd  = rd_req_in && (!wr_req_in || last_wr);

  always_comb begin
    state_nxt     = state;
    cs_nxt        = cs;
    addr_nxt      = addr;
    rdn_nxt       = rdn;
    wrn_nxt       = wrn;
    wd_nxt        = wd;
    rdata_nxt     = rdata;
    rvalid_nxt    = rvalid;
    ravail_nxt    = ravail;
    rdone_nxt     = 1'b0;
    wdone_nxt     = 1'b0;
    err_nxt       = 1'b0;
    init_done_nxt = init_done;
    last_wr_nxt   = last_wr;
    tcnt_nxt      = tcnt;
    bus_idle      = 1'b0;

    case (state)
      S_INIT: begin
        cs_nxt    = 1'b1;
        addr_nxt  = 1'b1;
        wrn_nxt   = 1'b0;
        wd_nxt    = CTRL_INIT;
        tcnt_nxt  = '0;
        state_nxt = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        // A timed-out init still unblocks the clients; there is nobody to flag.
        if (!bus.waitrequest_in || timed_out) begin
          bus_idle      = 1'b1;
          init_done_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      S_IDLE: begin
        if (grant_rd) begin
          cs_nxt      = 1'b1;
          rdn_nxt     = 1'b0;
          last_wr_nxt = 1'b0;
          tcnt_nxt    = '0;
          state_nxt   = S_RD_ACC;
        end else if (wr_req_in) begin
          cs_nxt      = 1'b1;
          wrn_nxt     = 1'b0;
          wd_nxt      = {24'h0, wr_data_in};
          last_wr_nxt = 1'b1;
          tcnt_nxt    = '0;
          state_nxt   = S_WR_ACC;
        end
      end
      S_RD_ACC: begin
        if (!bus.waitrequest_in) begin
          bus_idle   = 1'b1;
          rdone_nxt  = 1'b1;
          rdata_nxt  = bus.readdata_in[7:0];
          rvalid_nxt = bus.readdata_in[15];
          ravail_nxt = bus.readdata_in[31:16];
          state_nxt  = S_DONE;
        end else if (timed_out) begin
          bus_idle  = 1'b1;
          rdone_nxt = 1'b1;
          err_nxt   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      S_WR_ACC: begin
        if (!bus.waitrequest_in || timed_out) begin
          bus_idle  = 1'b1;
          wdone_nxt = 1'b1;
          err_nxt   = bus.waitrequest_in;
          state_nxt = S_DONE;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;   // forces at least one idle bus cycle
      default: state_nxt = S_INIT;
    endcase

    if (bus_idle) begin
      cs_nxt   = 1'b0;
      addr_nxt = 1'b0;
      rdn_nxt  = 1'b1;
      wrn_nxt  = 1'b1;
      wd_nxt   = '0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state     <= S_INIT;
      cs        <= 1'b0;
      addr      <= 1'b0;
      rdn       <= 1'b1;
      wrn       <= 1'b1;
      wd        <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      ravail    <= '0;
      rdone     <= 1'b0;
      wdone     <= 1'b0;
      err       <= 1'b0;
      init_done <= 1'b0;
      last_wr   <= 1'b1;
      tcnt      <= '0;
    end else begin
      state     <= state_nxt;
      cs        <= cs_nxt;
      addr      <= addr_nxt;
      rdn       <= rdn_nxt;
      wrn       <= wrn_nxt;
      wd        <= wd_nxt;
      rdata     <= rdata_nxt;
      rvalid    <= rvalid_nxt;
      ravail    <= ravail_nxt;
      rdone     <= rdone_nxt;
      wdone     <= wdone_nxt;
      err       <= err_nxt;
      init_done <= init_done_nxt;
      last_wr   <= last_wr_nxt;
      tcnt      <= tcnt_nxt;
    end
  end

  assign bus.chipselect_out = cs;
  assign bus.address_out    = addr;
  assign bus.read_n_out     = rdn;
  assign bus.write_n_out    = wrn;
  assign bus.writedata_out  = wd;
  assign rd_done_out        = rdone;
  assign rd_data_out        = rdata;
  assign rd_valid_out       = rvalid;
  assign rd_avail_out       = ravail;
  assign wr_done_out        = wdone;
  assign error_out          = err;
  assign init_done_out      = init_done;

endmodule

// File: tb/tb_uart_avalon_arbiter.sv
// Scoreboard bench for uart_avalon_arbiter: expected completions are queued as
// requests are raised and popped when a done pulse appears.
module tb_uart_avalon_arbiter;
  logic        clk = 1'b0;
  logic        reset_in;
  logic        rd_req_in, wr_req_in;
  logic [7:0]  wr_data_in;
  logic        rd_done_out, rd_valid_out, wr_done_out, error_out, init_done_out;
  logic [7:0]  rd_data_out;
  logic [15:0] rd_avail_out;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  typedef struct {
    logic        is_wr;
    logic [7:0]  data;
    logic        valid;
    logic [15:0] avail;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  uart_avalon_arbiter_if bus();

  uart_avalon_arbiter #(.CTRL_INIT(32'h0000_0001), .TIMEOUT_CYCLES(4)) dut (
    .clock_in(clk), .reset_in(reset_in),
    .rd_req_in(rd_req_in), .rd_done_out(rd_done_out), .rd_data_out(rd_data_out),
    .rd_valid_out(rd_valid_out), .rd_avail_out(rd_avail_out),
    .wr_req_in(wr_req_in), .wr_data_in(wr_data_in), .wr_done_out(wr_done_out),
    .error_out(error_out), .init_done_out(init_done_out), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays the Avalon slave for one access: stalls for 'stalls' cycles after the
  // first bus-active sample, then releases waitrequest. Returns at the done pulse.
  task automatic run_xfer(input int stalls, output int busy, output logic [31:0] wdata,
                          output logic got_rd, output logic got_wr, output logic got_err,
                          output logic ok);
    busy = 0; wdata = '0; got_rd = 0; got_wr = 0; got_err = 0; ok = 0;
    bus.waitrequest_in = (stalls > 0);
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (bus.chipselect_out) begin
        busy++;
        if (!bus.write_n_out) wdata = bus.writedata_out;
        if (busy == stalls + 1) bus.waitrequest_in = 1'b0;
      end
      if (rd_done_out || wr_done_out) begin
        got_rd = rd_done_out; got_wr = wr_done_out; got_err = error_out; ok = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.chipselect_out, bus.address_out, bus.read_n_out, bus.write_n_out} !== 4'b0011) begin
      errors++; $display("FAIL reset_bus got %b want 0011",
        {bus.chipselect_out, bus.address_out, bus.read_n_out, bus.write_n_out});
    end
    checks++;
    if (bus.writedata_out !== 32'h0) begin
      errors++; $display("FAIL reset_wdata got %h want 0", bus.writedata_out);
    end
    checks++;
    if ({init_done_out, rd_done_out, wr_done_out, error_out, rd_valid_out, rd_data_out, rd_avail_out} !== 29'h0) begin
      errors++; $display("FAIL reset_outputs got init=%b rdd=%b wrd=%b err=%b v=%b d=%h a=%h want all 0",
        init_done_out, rd_done_out, wr_done_out, error_out, rd_valid_out, rd_data_out, rd_avail_out);
    end
    reset_in = 1'b0;
    tick();
    checks++;
    if ({bus.chipselect_out, bus.address_out, bus.write_n_out, bus.read_n_out} !== 4'b1101 ||
        bus.writedata_out !== 32'h1 || init_done_out !== 1'b0) begin
      errors++; $display("FAIL init_write got cs=%b a=%b wn=%b rn=%b wd=%h init=%b want 1 1 0 1 00000001 0",
        bus.chipselect_out, bus.address_out, bus.write_n_out, bus.read_n_out, bus.writedata_out, init_done_out);
    end
    tick();
    checks++;
    if (bus.chipselect_out !== 1'b0 || bus.write_n_out !== 1'b1 || init_done_out !== 1'b1) begin
      errors++; $display("FAIL init_done got cs=%b wn=%b init=%b want 0 1 1",
        bus.chipselect_out, bus.write_n_out, init_done_out);
    end
  endtask

  task automatic test_arbitration();
    int busy; logic [31:0] wd; logic grd, gwr, gerr, ok; exp_t e;
    bus.readdata_in = 32'h0001_8077;
    wr_data_in = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      e.is_wr = (k % 2 == 1); e.data = e.is_wr ? 8'h5A : 8'h77;
      e.valid = 1'b1; e.avail = 16'h0001; e.err = 1'b0;
      sbq.push_back(e);
    end
    rd_req_in = 1'b1; wr_req_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_xfer(0, busy, wd, grd, gwr, gerr, ok);
      checks++;
      if (!ok || sbq.size() == 0) begin
        errors++; $display("FAIL arb_done_%0d got no done pulse want one", k);
      end else begin
        e = sbq.pop_front();
        checks++;
        if (gwr !== e.is_wr || grd !== !e.is_wr || gerr !== 1'b0) begin
          errors++; $display("FAIL arb_order_%0d got rd=%b wr=%b err=%b want wr=%b", k, grd, gwr, gerr, e.is_wr);
        end else if (e.is_wr) begin
          checks++;
          if (wd !== {24'h0, e.data}) begin
            errors++; $display("FAIL arb_wdata_%0d got %h want %h", k, wd, {24'h0, e.data});
          end
        end else begin
          checks++;
          if (rd_data_out !== e.data || rd_valid_out !== e.valid || rd_avail_out !== e.avail) begin
            errors++; $display("FAIL arb_rdata_%0d got %h %b %h want %h %b %h", k,
              rd_data_out, rd_valid_out, rd_avail_out, e.data, e.valid, e.avail);
          end
        end
      end
    end
    rd_req_in = 1'b0; wr_req_in = 1'b0;
  endtask

  task automatic test_read_stall();
    int busy; logic [31:0] wd; logic grd, gwr, gerr, ok; exp_t e;
    bus.readdata_in = 32'h0003_8041;
    e.is_wr = 1'b0; e.data = 8'h41; e.valid = 1'b1; e.avail = 16'h0003; e.err = 1'b0;
    sbq.push_back(e);
    rd_req_in = 1'b1;
    run_xfer(2, busy, wd, grd, gwr, gerr, ok);
    rd_req_in = 1'b0;
    checks++;
    if (!ok || !grd || gwr || gerr) begin
      errors++; $display("FAIL stall_done got ok=%b rd=%b wr=%b err=%b want 1 1 0 0", ok, grd, gwr, gerr);
    end
    checks++;
    if (busy != 3) begin
      errors++; $display("FAIL stall_len got %0d want 3 read cycles", busy);
    end
    e = sbq.pop_front();
    checks++;
    if (rd_data_out !== e.data || rd_valid_out !== e.valid || rd_avail_out !== e.avail) begin
      errors++; $display("FAIL stall_rdata got %h %b %h want %h %b %h",
        rd_data_out, rd_valid_out, rd_avail_out, e.data, e.valid, e.avail);
    end
  endtask

  task automatic test_write_timeout();
    int busy; logic [31:0] wd; logic grd, gwr, gerr, ok; exp_t e;
    e.is_wr = 1'b1; e.data = 8'hC3; e.valid = 1'b0; e.avail = 16'h0; e.err = 1'b1;
    sbq.push_back(e);
    wr_req_in = 1'b1; wr_data_in = 8'hC3;
    run_xfer(1000, busy, wd, grd, gwr, gerr, ok);
    wr_req_in = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (!ok || gwr !== 1'b1 || grd !== 1'b0 || gerr !== e.err) begin
      errors++; $display("FAIL timeout_done got ok=%b wr=%b rd=%b err=%b want 1 1 0 1", ok, gwr, grd, gerr);
    end
    checks++;
    if (busy != 4 || bus.chipselect_out !== 1'b0) begin
      errors++; $display("FAIL timeout_len got %0d cycles cs=%b want 4 cycles cs=0", busy, bus.chipselect_out);
    end
    checks++;
    if (wd !== {24'h0, e.data} || rd_data_out !== 8'h41) begin
      errors++; $display("FAIL timeout_data got wd=%h rd=%h want %h rd=41", wd, rd_data_out, {24'h0, e.data});
    end
    bus.waitrequest_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    int n_done = 0; int i;
    rd_req_in = 1'b1; bus.waitrequest_in = 1'b1;
    for (i = 0; i < 20 && !bus.chipselect_out; i++) begin
      tick();
      if (rd_done_out) n_done++;
    end
    checks++;
    if (bus.chipselect_out !== 1'b1 || bus.read_n_out !== 1'b0) begin
      errors++; $display("FAIL midrst_start got cs=%b rn=%b want 1 0", bus.chipselect_out, bus.read_n_out);
    end
    tick();
    reset_in = 1'b1;
    tick();
    if (rd_done_out) n_done++;
    checks++;
    if (bus.chipselect_out !== 1'b0 || bus.read_n_out !== 1'b1 || init_done_out !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got cs=%b rn=%b init=%b want 0 1 0",
        bus.chipselect_out, bus.read_n_out, init_done_out);
    end
    rd_req_in = 1'b0; bus.waitrequest_in = 1'b0; reset_in = 1'b0;
    tick();
    if (rd_done_out) n_done++;
    checks++;
    if ({bus.chipselect_out, bus.address_out, bus.write_n_out} !== 3'b110 || bus.writedata_out !== 32'h1) begin
      errors++; $display("FAIL midrst_init got cs=%b a=%b wn=%b wd=%h want 1 1 0 00000001",
        bus.chipselect_out, bus.address_out, bus.write_n_out, bus.writedata_out);
    end
    repeat (3) begin
      tick();
      if (rd_done_out) n_done++;
    end
    checks++;
    if (n_done != 0 || init_done_out !== 1'b1) begin
      errors++; $display("FAIL midrst_nodone got %0d pulses init=%b want 0 pulses init=1", n_done, init_done_out);
    end
  endtask

  task automatic test_back_to_back();
    int busy, prev; logic [31:0] wd; logic grd, gwr, gerr, ok; exp_t e;
    prev = 0;
    rd_req_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.is_wr = 1'b0; e.data = 8'h10 + 8'(k); e.valid = k[0]; e.avail = 16'(k + 5); e.err = 1'b0;
      sbq.push_back(e);
      bus.readdata_in = {e.avail, e.valid, 7'h0, e.data};
      run_xfer(0, busy, wd, grd, gwr, gerr, ok);
      e = sbq.pop_front();
      checks++;
      if (!ok || !grd || bus.chipselect_out !== 1'b0 || rd_data_out !== e.data ||
          rd_valid_out !== e.valid || rd_avail_out !== e.avail) begin
        errors++; $display("FAIL b2b_read_%0d got ok=%b rd=%b cs=%b %h %b %h want 1 1 0 %h %b %h", k, ok, grd,
          bus.chipselect_out, rd_data_out, rd_valid_out, rd_avail_out, e.data, e.valid, e.avail);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev != 3) begin
          errors++; $display("FAIL b2b_period_%0d got %0d cycles want 3", k, cyc - prev);
        end
      end
      prev = cyc;
    end
    rd_req_in = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset_in = 1'b1; rd_req_in = 1'b0; wr_req_in = 1'b0; wr_data_in = 8'h0;
    bus.readdata_in = 32'h0; bus.waitrequest_in = 1'b0;
    test_reset();
    test_arbitration();
    test_read_stall();
    test_write_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
